// File: rtl/mem_write_port.sv
// Write-side front end for the dual-port mem block: buffers single write requests in a
// small FIFO and runs an inclusive-range fill engine, both sharing one registered write port.
module mem_write_port #(
    parameter int unsigned DATA  = 8,
    parameter int unsigned ADDR  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_L,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR-1:0]          req_addr,
    input  logic [DATA-1:0]          req_data,
    input  logic                     fill_start,
    input  logic [ADDR-1:0]          fill_lo,
    input  logic [ADDR-1:0]          fill_hi,
    input  logic [DATA-1:0]          fill_val,
    input  logic                     stall,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     we,
    output logic [ADDR-1:0]          waddr,
    output logic [DATA-1:0]          wdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [ADDR-1:0] fifo_addr_q [DEPTH];
    logic [DATA-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [ADDR-1:0] cur_q, cur_d;
    logic [ADDR-1:0] hi_q, hi_d;
    logic [DATA-1:0] val_q, val_d;
    logic            busy_q, busy_d;
    logic            we_q, we_d;
    logic [ADDR-1:0] waddr_q, waddr_d;
    logic [DATA-1:0] wdata_q, wdata_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = (state_q == IDLE) && !full;
    assign push      = req_valid && req_ready;
    // The FIFO drains in IDLE and DRAIN; FILL owns the port exclusively.
    assign pop       = ((state_q == IDLE) || (state_q == DRAIN)) && !empty && !stall;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cur_d    = cur_q;
        hi_d     = hi_q;
        val_d    = val_q;
        busy_d   = busy_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            we_d     = 1'b1;
            waddr_d  = fifo_addr_q[rd_ptr_q];
            wdata_d  = fifo_data_q[rd_ptr_q];
        end
        count_d = count_q + CW'(push) - CW'(pop);

        case (state_q)
            IDLE: begin
                if (fill_start && (fill_lo <= fill_hi)) begin
                    cur_d   = fill_lo;
                    hi_d    = fill_hi;
                    val_d   = fill_val;
                    busy_d  = 1'b1;
                    // A same-cycle push leaves count_d non-zero, so it drains ahead of the fill.
                    state_d = (count_d == '0) ? FILL : DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (count_q == CW'(1))) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!stall) begin
                    we_d    = 1'b1;
                    waddr_d = cur_q;
                    wdata_d = val_q;
                    // Equality termination: an all-ones hi never wraps to address zero.
                    if (cur_q == hi_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cur_d = cur_q + ADDR'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
            hi_q     <= '0;
            val_q    <= '0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cur_q    <= cur_d;
            hi_q     <= hi_d;
            val_q    <= val_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push) begin
            fifo_addr_q[wr_ptr_q] <= req_addr;
            fifo_data_q[wr_ptr_q] <= req_data;
        end
    end

    assign busy  = busy_q;
    assign count = count_q;
    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_mem_write_port.sv
// Directed bench for mem_write_port: queued writes, backpressure, stall gaps, range fill,
// fill behind queued writes at the top of the address space, and reset during a fill.
module tb_mem_write_port;

    logic        clk;
    logic        rst_L;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic        fill_start;
    logic [15:0] fill_lo;
    logic [15:0] fill_hi;
    logic [7:0]  fill_val;
    logic        stall;
    logic        busy;
    logic [2:0]  count;
    logic        we;
    logic [15:0] waddr;
    logic [7:0]  wdata;

    int checks;
    int errors;
    int cyc;

    logic [31:0] log_a [$];
    logic [31:0] log_d [$];
    int          log_c [$];
    logic [31:0] exp_a [$];
    logic [31:0] exp_d [$];

    mem_write_port #(
        .DATA  (8),
        .ADDR  (16),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .fill_start (fill_start),
        .fill_lo    (fill_lo),
        .fill_hi    (fill_hi),
        .fill_val   (fill_val),
        .stall      (stall),
        .busy       (busy),
        .count      (count),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every issued write in the middle of its cycle.
    always @(negedge clk) begin
        if (rst_L && we) begin
            log_a.push_back(32'(waddr));
            log_d.push_back(32'(wdata));
            log_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_nwrites"}, 32'(log_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_a[i], exp_a[i]);
            check($sformatf("%s_data%0d", tag, i), log_d[i], exp_d[i]);
        end
        exp_a.delete();
        exp_d.delete();
        clear_log();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_L      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        fill_start = 1'b0;
        fill_lo    = '0;
        fill_hi    = '0;
        fill_val   = '0;
        stall      = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_we", 32'(we), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        @(negedge clk);
        rst_L = 1'b1;
        step();
        check("rst_ready", 32'(req_ready), 1);

        // Single write: push at edge N, write visible after edge N+1
        clear_log();
        req_valid = 1'b1;
        req_addr  = 16'h1234;
        req_data  = 8'h5A;
        step();
        req_valid = 1'b0;
        check("single_cnt1", 32'(count), 1);
        check("single_we0", 32'(we), 0);
        step();
        check("single_we1", 32'(we), 1);
        check("single_addr", 32'(waddr), 32'h1234);
        check("single_data", 32'(wdata), 32'h5A);
        check("single_cnt0", 32'(count), 0);
        step();
        check("single_we_off", 32'(we), 0);
        expect_wr(32'h1234, 32'h5A);
        check_log("single");

        // Backpressure with stall held high
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 16'h0100 + 16'(i);
            req_data  = 8'h10 + 8'(i);
            check($sformatf("bp_ready%0d", i), 32'(req_ready), 1);
            step();
        end
        req_addr = 16'h0104;
        req_data = 8'h14;
        check("bp_full_ready", 32'(req_ready), 0);
        check("bp_count", 32'(count), 4);
        step();
        check("bp_count_hold", 32'(count), 4);
        check("bp_we_stalled", 32'(we), 0);
        stall = 1'b0;
        step();
        check("bp_first_we", 32'(we), 1);
        check("bp_first_addr", 32'(waddr), 32'h0100);
        check("bp_ready_again", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        repeat (6) step();
        check("bp_consecutive", 32'(log_c.size() == 5 ? log_c[4] - log_c[0] : -1), 4);
        for (int i = 0; i < 5; i++) expect_wr(32'h0100 + 32'(i), 32'h10 + 32'(i));
        check_log("bp");

        // Stall gap in the middle of a stream
        req_valid = 1'b1;
        req_addr  = 16'h0300;
        req_data  = 8'h31;
        step();
        req_addr  = 16'h0301;
        req_data  = 8'h32;
        step();
        check("gap_first_we", 32'(we), 1);
        req_addr  = 16'h0302;
        req_data  = 8'h33;
        stall     = 1'b1;
        step();
        check("gap_we_low1", 32'(we), 0);
        req_valid = 1'b0;
        step();
        check("gap_we_low2", 32'(we), 0);
        check("gap_count", 32'(count), 2);
        stall = 1'b0;
        repeat (4) step();
        expect_wr(32'h0300, 32'h31);
        expect_wr(32'h0301, 32'h32);
        expect_wr(32'h0302, 32'h33);
        check_log("gap");

        // Range fill on empty FIFO
        fill_lo    = 16'h0010;
        fill_hi    = 16'h0013;
        fill_val   = 8'hAA;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        check("fill_busy", 32'(busy), 1);
        check("fill_we0", 32'(we), 0);
        check("fill_ready", 32'(req_ready), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("fill_we%0d", i), 32'(we), 1);
            check($sformatf("fill_addr%0d", i), 32'(waddr), 32'h0010 + 32'(i));
            check($sformatf("fill_data%0d", i), 32'(wdata), 32'hAA);
            check($sformatf("fill_busy%0d", i), 32'(busy), (i == 3) ? 0 : 1);
        end
        step();
        check("fill_done_we", 32'(we), 0);
        check("fill_done_ready", 32'(req_ready), 1);
        clear_log();

        // Inverted range is ignored
        fill_lo    = 16'h0020;
        fill_hi    = 16'h001F;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        check("inv_busy", 32'(busy), 0);
        check("inv_ready", 32'(req_ready), 1);
        repeat (3) step();
        check_log("inv");

        // Fill queued behind two writes, ending at the top of the address space
        stall     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 16'h0200;
        req_data  = 8'h11;
        step();
        req_addr  = 16'h0201;
        req_data  = 8'h22;
        step();
        req_valid  = 1'b0;
        fill_lo    = 16'hFFFE;
        fill_hi    = 16'hFFFF;
        fill_val   = 8'h00;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        check("top_busy", 32'(busy), 1);
        check("top_count", 32'(count), 2);
        check("top_drain_ready", 32'(req_ready), 0);
        stall = 1'b0;
        repeat (8) step();
        check("top_busy_end", 32'(busy), 0);
        expect_wr(32'h0200, 32'h11);
        expect_wr(32'h0201, 32'h22);
        expect_wr(32'hFFFE, 32'h00);
        expect_wr(32'hFFFF, 32'h00);
        check_log("top");

        // Reset during a long fill
        fill_lo    = 16'h0000;
        fill_hi    = 16'h00FF;
        fill_val   = 8'h5C;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        repeat (10) step();
        check("rmf_we", 32'(we), 1);
        check("rmf_addr", 32'(waddr), 32'h0009);
        rst_L = 1'b0;
        #1;
        check("rmf_rst_we", 32'(we), 0);
        check("rmf_rst_busy", 32'(busy), 0);
        check("rmf_rst_count", 32'(count), 0);
        clear_log();
        @(negedge clk);
        rst_L = 1'b1;
        repeat (20) step();
        check("rmf_post_busy", 32'(busy), 0);
        check("rmf_post_we", 32'(we), 0);
        check_log("rmf");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
